// File: rtl/reg_cmd_pkg.sv
// Shared types and constants for the register command sequencer.
// - ctrl_state_e : top-level command FSM states. The three transmit phases
//                  (byte 0, gap, byte 1) are sequenced inside reg_cmd_tx_seq.
//                  The top FSM waits in StTx until that sequencer reports done.
// - tx_state_e   : transmit sequencer phases.
// - CMD_*        : command opcodes, each carried in the first byte of a frame.
package reg_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StAluA,
        StAluB,
        StAluFun,
        StAluWait,
        StTx
    } ctrl_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxB0,
        TxGap,
        TxB1
    } tx_state_e;

endpackage

// File: rtl/reg_cmd_ctrl_if.sv
// Bus bundle between the command sequencer and its environment.
// Signal groups: the UART RX byte stream, the register-file port, the ALU
// port, the UART TX handshake, and the error pulse.
// Modports:
// - master : the sequencer side.
// - slave  : the register file, ALU and UART side.
interface reg_cmd_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) ();
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic                    WrEn;
    logic                    RdEn;
    logic [ADDR_WIDTH-1:0]   Address;
    logic [DATA_WIDTH-1:0]   WrData;
    logic [DATA_WIDTH-1:0]   RdData;
    logic                    RdData_Valid;
    logic                    ALU_EN;
    logic [3:0]              ALU_FUN;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_VLD;
    logic                    CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    TX_BUSY;
    logic                    CMD_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
        output TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
        input  TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface

// File: rtl/reg_cmd_tx_seq.sv
// Serialises one or two bytes onto the TX valid/busy handshake.
// Inputs:
// - clk_i, rst_i : clock and asynchronous active-high reset.
// - start_i      : one-cycle request. data_i and nbytes_i are sampled with it.
// - nbytes_i     : number of bytes to send (1 or 2).
// - data_i       : the payload. The low byte is sent first.
// - tx_busy_i    : transmitter busy.
// Outputs:
// - tx_p_data_o, tx_d_vld_o : the presented byte and its valid flag.
// - done_o       : one-cycle pulse after the last byte is accepted.
// A byte is accepted on a cycle where valid is high and busy is low.
// Valid always drops for at least one cycle between the two bytes.
module reg_cmd_tx_seq
    import reg_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [1:0]              nbytes_i,
    input  logic [2*DATA_WIDTH-1:0] data_i,
    input  logic                    tx_busy_i,
    output logic [DATA_WIDTH-1:0]   tx_p_data_o,
    output logic                    tx_d_vld_o,
    output logic                    done_o
);
    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic                  two_q, two_d;
    logic                  vld_q, vld_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        hi_d    = hi_q;
        two_d   = two_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        case (state_q)
            TxIdle: begin
                if (start_i) begin
                    data_d  = data_i[DATA_WIDTH-1:0];
                    hi_d    = data_i[2*DATA_WIDTH-1:DATA_WIDTH];
                    two_d   = (nbytes_i == 2'd2);
                    vld_d   = 1'b1;
                    state_d = TxB0;
                end
            end
            TxB0: begin
                if (!tx_busy_i) begin
                    vld_d = 1'b0;
                    if (two_q) begin
                        state_d = TxGap;
                    end else begin
                        done_d  = 1'b1;
                        state_d = TxIdle;
                    end
                end
            end
            // Valid is low for this whole cycle; present the high byte next.
            TxGap: begin
                data_d  = hi_q;
                vld_d   = 1'b1;
                state_d = TxB1;
            end
            TxB1: begin
                if (!tx_busy_i) begin
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = TxIdle;
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= TxIdle;
            data_q  <= '0;
            hi_q    <= '0;
            two_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            hi_q    <= hi_d;
            two_q   <= two_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign tx_p_data_o = data_q;
    assign tx_d_vld_o  = vld_q;
    assign done_o      = done_q;
endmodule

// File: rtl/reg_cmd_ctrl.sv
// Command sequencer between the UART byte stream and the register file / ALU.
// It decodes RX command frames (WRITE, READ, ALU_OP, ALU_NOP) and drives the
// following, all registered:
// - the register-file write and read strobes;
// - ALU start, ALU function and the ALU clock-gate enable;
// - read data and ALU results, returned through reg_cmd_tx_seq.
// Ports:
// - CLK, RST : clock and asynchronous active-high reset.
// - bus      : reg_cmd_ctrl_if master modport.
// Timeout: RD_WAIT and ALU_WAIT give up after TIMEOUT+1 cycles without a
// valid response. CMD_ERR then pulses and the FSM returns to idle.
module reg_cmd_ctrl
    import reg_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned OPA_ADDR   = 0,
    parameter int unsigned OPB_ADDR   = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic            CLK,
    input logic            RST,
    reg_cmd_ctrl_if.master bus
);
    localparam int unsigned           CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]       CntMax  = CntW'(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] OpaAddr = ADDR_WIDTH'(OPA_ADDR);
    localparam logic [ADDR_WIDTH-1:0] OpbAddr = ADDR_WIDTH'(OPB_ADDR);

    ctrl_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    alu_en_q, alu_en_d;
    logic [3:0]              alu_fun_q, alu_fun_d;
    logic                    clk_gate_q, clk_gate_d;
    logic                    cmd_err_q, cmd_err_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    tx_start_q, tx_start_d;
    logic [1:0]              tx_nbytes_q, tx_nbytes_d;
    logic [2*DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                    tx_done;

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = rd_en_q;
        alu_en_d    = 1'b0;
        alu_fun_d   = alu_fun_q;
        clk_gate_d  = clk_gate_q;
        cmd_err_d   = 1'b0;
        cnt_d       = cnt_q;
        tx_start_d  = 1'b0;
        tx_nbytes_d = tx_nbytes_q;
        tx_buf_d    = tx_buf_q;
        case (state_q)
            StIdle: begin
                if (bus.RX_D_VLD) begin
                    case (bus.RX_P_DATA)
                        DATA_WIDTH'(CMD_WR):      state_d = StWrAddr;
                        DATA_WIDTH'(CMD_RD):      state_d = StRdAddr;
                        DATA_WIDTH'(CMD_ALU_OP):  state_d = StAluA;
                        DATA_WIDTH'(CMD_ALU_NOP): state_d = StAluFun;
                        default:                  cmd_err_d = 1'b1;
                    endcase
                end
            end
            StWrAddr: begin
                if (bus.RX_D_VLD) begin
                    address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = StWrData;
                end
            end
            StWrData: begin
                if (bus.RX_D_VLD) begin
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = StIdle;
                end
            end
            StRdAddr: begin
                if (bus.RX_D_VLD) begin
                    address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (bus.RX_D_VLD) cmd_err_d = 1'b1;
                if (bus.RdData_Valid) begin
                    rd_en_d     = 1'b0;
                    tx_buf_d    = {{DATA_WIDTH{1'b0}}, bus.RdData};
                    tx_nbytes_d = 2'd1;
                    tx_start_d  = 1'b1;
                    state_d     = StTx;
                end else if (cnt_q == CntMax) begin
                    rd_en_d   = 1'b0;
                    cmd_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAluA: begin
                if (bus.RX_D_VLD) begin
                    address_d = OpaAddr;
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = StAluB;
                end
            end
            StAluB: begin
                if (bus.RX_D_VLD) begin
                    address_d = OpbAddr;
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = StAluFun;
                end
            end
            StAluFun: begin
                if (bus.RX_D_VLD) begin
                    alu_fun_d  = bus.RX_P_DATA[3:0];
                    alu_en_d   = 1'b1;
                    clk_gate_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StAluWait;
                end
            end
            StAluWait: begin
                if (bus.RX_D_VLD) cmd_err_d = 1'b1;
                if (bus.ALU_OUT_VLD) begin
                    clk_gate_d  = 1'b0;
                    tx_buf_d    = bus.ALU_OUT;
                    tx_nbytes_d = 2'd2;
                    tx_start_d  = 1'b1;
                    state_d     = StTx;
                end else if (cnt_q == CntMax) begin
                    clk_gate_d = 1'b0;
                    cmd_err_d  = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTx: begin
                if (bus.RX_D_VLD) cmd_err_d = 1'b1;
                if (tx_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            address_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_fun_q   <= '0;
            clk_gate_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            cnt_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_nbytes_q <= '0;
            tx_buf_q    <= '0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            alu_en_q    <= alu_en_d;
            alu_fun_q   <= alu_fun_d;
            clk_gate_q  <= clk_gate_d;
            cmd_err_q   <= cmd_err_d;
            cnt_q       <= cnt_d;
            tx_start_q  <= tx_start_d;
            tx_nbytes_q <= tx_nbytes_d;
            tx_buf_q    <= tx_buf_d;
        end
    end

    reg_cmd_tx_seq #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tx_seq (
        .clk_i      (CLK),
        .rst_i      (RST),
        .start_i    (tx_start_q),
        .nbytes_i   (tx_nbytes_q),
        .data_i     (tx_buf_q),
        .tx_busy_i  (bus.TX_BUSY),
        .tx_p_data_o(bus.TX_P_DATA),
        .tx_d_vld_o (bus.TX_D_VLD),
        .done_o     (tx_done)
    );

    assign bus.WrEn        = wr_en_q;
    assign bus.RdEn        = rd_en_q;
    assign bus.Address     = address_q;
    assign bus.WrData      = wr_data_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.CLK_GATE_EN = clk_gate_q;
    assign bus.CMD_ERR     = cmd_err_q;
endmodule

// File: doc/reg_cmd_ctrl.md
Name: reg_cmd_ctrl

Overview:
Command sequencer between the UART byte stream and the register file / ALU datapath. It decodes command frames from RX bytes and drives register-file write/read strobes, ALU enable/function and the ALU clock-gate enable. Read data and ALU results are returned as bytes over the TX valid/busy handshake. It is the single master of the register file.

Parameters:
DATA_WIDTH, 8, byte/register width
ADDR_WIDTH, 4, register-file address width
OPA_ADDR, 0, register address for ALU operand A
OPB_ADDR, 1, register address for ALU operand B
TIMEOUT, 255, max wait cycles for RdData_Valid / ALU_OUT_VLD

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
WrEn  out  1  register-file write strobe
RdEn  out  1  register-file read request
Address  out  ADDR_WIDTH  register-file address
WrData  out  DATA_WIDTH  register-file write data
RdData  in  DATA_WIDTH  register-file read data
RdData_Valid  in  1  read data valid
ALU_EN  out  1  one-cycle ALU start
ALU_FUN  out  4  ALU function code
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid
CLK_GATE_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  TX data valid
TX_BUSY  in  1  transmitter busy
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- One clock, CLK. RST is asynchronous and active-high. All outputs are registered and reset to 0; the FSM resets to IDLE. A reset mid-frame aborts the frame with no pending strobe.
- Commands are decoded from the first byte received in IDLE:
  - 0xAA WRITE: addr, data
  - 0xBB READ: addr
  - 0xCC ALU_OP: A, B, fun
  - 0xDD ALU_NOP: fun
  - Any other byte: pulse CMD_ERR, stay in IDLE.
- Address uses byte[ADDR_WIDTH-1:0]; ALU_FUN uses byte[3:0]. Upper bits are ignored.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_B0, TX_GAP, TX_B1.
- WRITE:
  - WR_ADDR latches the address.
  - WR_DATA, on RX_D_VLD: the next cycle has WrEn=1 for exactly one cycle, with Address/WrData set. Then IDLE.
- READ:
  - RD_ADDR latches the address, then RD_WAIT.
  - RD_WAIT holds RdEn=1 and Address stable until RdData_Valid=1.
  - On RdData_Valid, RdData is captured; RdEn deasserts the next cycle.
  - Then TX_B0 with one byte, then IDLE.
- ALU_OP:
  - ALU_A writes its byte to OPA_ADDR; ALU_B writes its byte to OPB_ADDR. Each is a one-cycle WrEn, same timing as WRITE.
  - ALU_FUN, on RX_D_VLD: the next cycle has ALU_EN=1 (one cycle), ALU_FUN latched, CLK_GATE_EN=1.
  - ALU_WAIT holds CLK_GATE_EN=1 until ALU_OUT_VLD. ALU_OUT is captured and CLK_GATE_EN clears the next cycle.
  - Transmit low byte (TX_B0), then high byte (TX_B1), then IDLE.
- ALU_NOP: goes directly to ALU_FUN; the operands are the current register contents.
- TX handshake:
  - A byte is presented with TX_D_VLD=1 and TX_P_DATA held stable until a cycle with TX_BUSY=0 (accepted).
  - TX_D_VLD drops the following cycle.
  - TX_GAP inserts one idle cycle (TX_D_VLD=0) before TX_B1.
  - TX_D_VLD is never high two consecutive cycles across bytes.
- Timeout:
  - A counter (clog2(TIMEOUT+1) bits) runs in RD_WAIT and ALU_WAIT.
  - Reaching TIMEOUT pulses CMD_ERR, deasserts RdEn/CLK_GATE_EN next cycle and returns to IDLE with no TX.
  - The counter clears on state entry.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT or TX states: the byte is dropped and CMD_ERR pulses. No state change.
- WrEn and RdEn are never high in the same cycle. ALU_EN is never high while WrEn is high.

Decomposition:
- Package reg_cmd_pkg: state enum; command opcode constants CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD.
- One sub-module, reg_cmd_tx_seq: serialises 1 or 2 bytes onto the TX handshake, including the gap; it has start, nbytes, data and done.
- FSM and timeout counter stay in reg_cmd_ctrl.

Test Plan:
- Bytes AA,05,3C -> exactly one WrEn cycle with Address=5, WrData=0x3C; no TX; CMD_ERR=0.
- Bytes BB,05, RdData=0x3C valid after 3 cycles -> RdEn high until valid; TX_P_DATA=0x3C sent once, including under TX_BUSY=1 for 10 cycles.
- Bytes CC,07,09,00, ALU_OUT=0x0010 -> WrEn @0=07, WrEn @1=09; ALU_EN pulse with FUN=0; CLK_GATE_EN high through ALU_WAIT; TX 0x10 then 0x00 with gap.
- Bytes DD,02 -> no WrEn; ALU_EN with FUN=2; two TX bytes.
- Byte 0x55 in IDLE -> CMD_ERR pulse, state IDLE; BB,03 with RdData_Valid never asserted -> CMD_ERR after 255 cycles, RdEn low, no TX.
- RST asserted during ALU_WAIT -> all outputs 0 immediately; next AA frame works normally.
